addsub_serial_ctrl: RTL and testbench

Sequencer that performs WIDTH-bit two's-complement add/subtract by reusing one 4-bit add/sub slice over WIDTH/4 consecutive cycles, LSB nibble first. It latches operands, drives the slice's operands and carry-in each cycle, and chains the carry through a register. It reports unsigned carry-out and signed overflow. It sits between an issuing unit and the shared nibble adder, using a valid/ready handshake on both sides.

---
 rtl/addsub_serial_ctrl.sv | 110 +++++++++++
 tb/tb_addsub_serial_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_ctrl.sv
// Bit-serial-by-nibble add/subtract sequencer: one 4-bit slice reused over NIB cycles, LSB nibble first.
// Latency NIB cycles from accept to out_valid; result held in DONE until out_ready, no request accepted meanwhile.
module addsub_serial_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovfl,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_lat;
  logic [WIDTH-1:0] b_lat;
  logic             sub_lat;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [IW+1:0]    base;
  logic [3:0]       a_nib;
  logic [3:0]       b_eff;
  logic [4:0]       slice;

  // Shared nibble slice: B is inverted for subtract, the +1 enters via the carry register.
  always_comb begin
    base  = {idx, 2'b00};
    a_nib = a_lat[base +: 4];
    b_eff = b_lat[base +: 4] ^ {4{sub_lat}};
    slice = {1'b0, a_nib} + {1'b0, b_eff} + {4'b0000, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_lat     <= '0;
      b_lat     <= '0;
      sub_lat   <= 1'b0;
      carry     <= 1'b0;
      idx       <= '0;
      result    <= '0;
      cout      <= 1'b0;
      ovfl      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_lat    <= a;
            b_lat    <= b;
            sub_lat  <= sub;
            carry    <= sub;
            idx      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          result[base +: 4] <= slice[3:0];
          carry             <= slice[4];
          if (idx == IW'(NIB - 1)) begin
            cout      <= slice[4];
            // Both operands share a sign but the sum's sign differs.
            ovfl      <= (a_nib[3] == b_eff[3]) && (slice[3] != a_nib[3]);
            idx       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Bench for addsub_serial_ctrl: directed table, backpressure/reset sequences, random regression vs arithmetic model.
module tb_addsub_serial_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
  logic         ovfl;
  logic         busy;

  int checks = 0;
  int errors = 0;

  addsub_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .ovfl(ovfl), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] r;
    logic         c;
    logic         o;
    int           hold;
    bit           pre;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference from plain integer arithmetic: range checks, not carry chains.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                       output logic [W-1:0] r, output logic c, output logic o);
    longint ux, uy, sx, sy, ur, sr;
    ux = longint'(x);
    uy = longint'(y);
    sx = (ux >= (64'sd1 <<< (W - 1))) ? ux - (64'sd1 <<< W) : ux;
    sy = (uy >= (64'sd1 <<< (W - 1))) ? uy - (64'sd1 <<< W) : uy;
    ur = s ? ux - uy : ux + uy;
    sr = s ? sx - sy : sx + sy;
    r  = W'(ur);
    c  = s ? (ux >= uy) : (ur >= (64'sd1 <<< W));
    o  = (sr > (64'sd1 <<< (W - 1)) - 1) || (sr < -(64'sd1 <<< (W - 1)));
  endtask

  // One transaction; scrambles a/b/sub after acceptance, holds out_ready low 'hold' cycles,
  // and optionally raises a second in_valid while the result is waiting.
  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
                        input int hold, input bit pre, input bit poke,
                        output logic [W-1:0] r, output logic c, output logic o, output int lat);
    int guard;
    out_ready = pre;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    a = xa; b = xb; sub = xs; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result; c = cout; o = ovfl;
    if (!pre) begin
      for (int k = 0; k < hold; k++) begin
        if (poke) begin
          in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
        end
        @(posedge clk); #1;
        if (poke) begin
          chk("hold_result", 32'(result), 32'(r));
          chk("hold_flags", {30'd0, cout, ovfl}, {30'd0, c, o});
          chk("hold_hs", {30'd0, out_valid, in_ready}, 32'd2);
        end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("release_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    if (poke) chk("poke_ignored_busy", {31'd0, busy}, 32'd0);
  endtask

  vec_t         tbl[$];
  logic [W-1:0] r, er;
  logic         c, o, ec, eo;
  int           lat;
  bit           seen_valid;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    #3;
    chk("reset_outputs", {11'd0, result, cout, ovfl, out_valid, busy}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);

    tbl.push_back('{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0, 0, 1'b0});
    tbl.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1, 1'b0});
    tbl.push_back('{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 0, 1'b1});
    tbl.push_back('{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 2, 1'b0});
    tbl.push_back('{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1});
    tbl.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 1'b0});
    tbl.push_back('{16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0, 3, 1'b0});
    tbl.push_back('{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 0, 1'b0});
    tbl.push_back('{16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b0, 0, 1'b1});

    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].hold, tbl[i].pre, 1'b0, r, c, o, lat);
      chk($sformatf("vec%0d_result", i), 32'(r), 32'(tbl[i].r));
      chk($sformatf("vec%0d_cout", i), {31'd0, c}, {31'd0, tbl[i].c});
      chk($sformatf("vec%0d_ovfl", i), {31'd0, o}, {31'd0, tbl[i].o});
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(NIB));
    end

    // Long backpressure with a second request attempted while DONE.
    run_op(16'h1111, 16'h2222, 1'b0, 10, 1'b0, 1'b1, r, c, o, lat);
    chk("bp_result", 32'(r), 32'h3333);

    // Reset two cycles into RUN aborts without a result.
    @(negedge clk);
    a = 16'hABCD; b = 16'h1234; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_abort_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", {11'd0, result, cout, ovfl, out_valid, busy}, 32'd0);
    seen_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen_valid = 1'b1;
    end
    chk("abort_no_out_valid", {31'd0, seen_valid}, 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 0, 1'b0, 1'b0, r, c, o, lat);
    chk("post_abort_result", 32'(r), 32'h0100);
    chk("post_abort_latency", 32'(lat), 32'(NIB));

    for (int n = 0; n < 1000; n++) begin
      logic [W-1:0] ra, rb;
      logic         rs;
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      if (n % 7 == 0) rb = ra;
      run_op(ra, rb, rs, $urandom_range(0, 2), 1'($urandom), 1'b0, r, c, o, lat);
      model(ra, rb, rs, er, ec, eo);
      chk($sformatf("rnd%0d_result", n), 32'(r), 32'(er));
      chk($sformatf("rnd%0d_flags", n), {30'd0, c, o}, {30'd0, ec, eo});
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(NIB));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
